// File: rtl/pix_ram_arbiter.sv
// Round-robin read arbiter sharing one 60x60 pixel RAM among scanning engines.
// Fixed 2-cycle grant-to-data latency, one read per cycle, no back-pressure.
module pix_ram_arbiter #(
    parameter int unsigned NREQ    = 3,
    parameter int unsigned XSZ     = 6,
    parameter int unsigned YSZ     = 6,
    parameter int unsigned ADDRSZ  = 12,
    parameter int unsigned COLSZ   = 3,
    parameter int unsigned XRES    = 60,
    parameter int unsigned YRES    = 60,
    parameter int unsigned OOB_VAL = 0
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*XSZ-1:0]   req_x,
    input  logic [NREQ*YSZ-1:0]   req_y,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       rd_valid,
    output logic [COLSZ-1:0]      rd_data,
    output logic [ADDRSZ-1:0]     ram_addr,
    input  logic [COLSZ-1:0]      ram_q,
    output logic                  busy
);

    localparam int unsigned TW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [XSZ:0] XLIM = (XSZ + 1)'(XRES);
    localparam logic [YSZ:0] YLIM = (YSZ + 1)'(YRES);

    logic [TW-1:0]     r_rr;
    logic              r_s1_v, r_s2_v;
    logic [TW-1:0]     r_s1_tag, r_s2_tag;
    logic              r_s1_oob, r_s2_oob;
    logic [ADDRSZ-1:0] r_ram_addr;

    logic              w_gnt_any;
    logic [TW-1:0]     w_gidx;
    logic [TW-1:0]     w_rr_nxt;
    logic [XSZ-1:0]    w_x;
    logic [YSZ-1:0]    w_y;
    logic [ADDRSZ-1:0] w_x_ext, w_y_ext, w_addr;
    logic              w_oob;

    // Two passes: first from rr upward, then wrap to the indices below rr.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gidx    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_gnt_any && req[i] && (i >= int'(r_rr))) begin
                w_gnt_any = 1'b1;
                w_gidx    = TW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!w_gnt_any && req[i]) begin
                w_gnt_any = 1'b1;
                w_gidx    = TW'(i);
            end
        end
        if (!resetn) begin
            w_gnt_any = 1'b0;
        end
        gnt = '0;
        if (w_gnt_any) begin
            gnt[w_gidx] = 1'b1;
        end
    end

    assign w_rr_nxt = (w_gidx == TW'(NREQ - 1)) ? '0 : w_gidx + 1'b1;
    assign w_x      = req_x[w_gidx*XSZ +: XSZ];
    assign w_y      = req_y[w_gidx*YSZ +: YSZ];
    assign w_x_ext  = ADDRSZ'(w_x);
    assign w_y_ext  = ADDRSZ'(w_y);
    assign w_oob    = ({1'b0, w_x} >= XLIM) || ({1'b0, w_y} >= YLIM);

    generate
        if (XRES == 60) begin : g_addr_60
            // 60 = 32 + 16 + 8 + 4, so the multiply reduces to shifted adds.
            assign w_addr = (w_y_ext << 5) + (w_y_ext << 4) + (w_y_ext << 3)
                          + (w_y_ext << 2) + w_x_ext;
        end else begin : g_addr_mul
            assign w_addr = w_y_ext * ADDRSZ'(XRES) + w_x_ext;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rr       <= '0;
            r_s1_v     <= 1'b0;
            r_s2_v     <= 1'b0;
            r_s1_tag   <= '0;
            r_s2_tag   <= '0;
            r_s1_oob   <= 1'b0;
            r_s2_oob   <= 1'b0;
            r_ram_addr <= '0;
        end else begin
            r_s1_v <= w_gnt_any;
            if (w_gnt_any) begin
                r_rr       <= w_rr_nxt;
                r_s1_tag   <= w_gidx;
                r_s1_oob   <= w_oob;
                r_ram_addr <= w_addr;
            end
            r_s2_v   <= r_s1_v;
            r_s2_tag <= r_s1_tag;
            r_s2_oob <= r_s1_oob;
        end
    end

    // Reads already in flight when reset is asserted must never be reported.
    always_comb begin
        rd_valid = '0;
        if (resetn && r_s2_v) begin
            rd_valid[r_s2_tag] = 1'b1;
        end
    end

    assign rd_data  = r_s2_oob ? COLSZ'(OOB_VAL) : ram_q;
    assign ram_addr = r_ram_addr;
    assign busy     = resetn & (r_s1_v | r_s2_v);

endmodule

// File: tb/tb_pix_ram_arbiter.sv
// Bench for pix_ram_arbiter: directed scenarios then random traffic, all
// checked against a transaction-level model of grants and returned pixels.
module tb_pix_ram_arbiter;

    localparam int NREQ = 3;
    localparam int XRES = 60;
    localparam int YRES = 60;

    logic        clk = 1'b0;
    logic        resetn;
    logic [2:0]  req;
    logic [17:0] req_x, req_y;
    logic [2:0]  gnt, rd_valid, rd_data;
    logic [11:0] ram_addr;
    logic [2:0]  ram_q;
    logic        busy;

    always #5 clk = ~clk;

    pix_ram_arbiter dut (
        .clk      (clk),
        .resetn   (resetn),
        .req      (req),
        .req_x    (req_x),
        .req_y    (req_y),
        .gnt      (gnt),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .ram_addr (ram_addr),
        .ram_q    (ram_q),
        .busy     (busy)
    );

    logic [2:0] mem [0:3599];

    always @(posedge clk) begin
        if (ram_addr < 12'd3600) ram_q <= mem[ram_addr];
        else                     ram_q <= 3'($urandom);
    end

    typedef struct {
        int due;
        int tag;
        int data;
    } rd_t;

    rd_t        pend[$];
    int         m_rr;
    int         cyc;
    int         exp_addr;
    bit         addr_known;
    logic [2:0] last_gnt;
    int         n_vec;
    int         n_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [2:0] r, input int rr);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(rr + k) % NREQ]) return (rr + k) % NREQ;
        end
        return -1;
    endfunction

    // One clock cycle: check outputs mid-cycle, then advance the model at the edge.
    task automatic cycle();
        int         g;
        int         x, y;
        bit         oob;
        logic [2:0] exp_gnt, exp_rv;
        int         exp_data;
        @(negedge clk);
        g       = resetn ? pick(req, m_rr) : -1;
        exp_gnt = (g < 0) ? 3'b000 : 3'(1 << g);
        check_eq("gnt", 32'(gnt), 32'(exp_gnt));
        exp_rv   = 3'b000;
        exp_data = 0;
        foreach (pend[k]) begin
            if (pend[k].due == cyc && resetn) begin
                exp_rv   = 3'(1 << pend[k].tag);
                exp_data = pend[k].data;
            end
        end
        check_eq("rd_valid", 32'(rd_valid), 32'(exp_rv));
        if (exp_rv != 3'b000) check_eq("rd_data", 32'(rd_data), 32'(exp_data));
        check_eq("busy", 32'(busy), 32'(resetn && pend.size() > 0));
        if (addr_known) check_eq("ram_addr", 32'(ram_addr), 32'(exp_addr));
        @(posedge clk);
        if (!resetn) begin
            m_rr       = 0;
            pend.delete();
            exp_addr   = 0;
            addr_known = 1'b1;
        end else begin
            while (pend.size() > 0 && pend[0].due <= cyc) void'(pend.pop_front());
            if (g >= 0) begin
                x   = int'(req_x[g*6 +: 6]);
                y   = int'(req_y[g*6 +: 6]);
                oob = (x >= XRES) || (y >= YRES);
                pend.push_back('{cyc + 2, g, oob ? 0 : int'(mem[y*XRES + x])});
                m_rr = (g + 1) % NREQ;
                if (oob) begin
                    addr_known = 1'b0;
                end else begin
                    addr_known = 1'b1;
                    exp_addr   = y*XRES + x;
                end
            end
        end
        last_gnt = exp_gnt;
        cyc++;
        #1;
    endtask

    task automatic set_req(input int i, input bit on, input int x, input int y);
        req[i]          = on;
        req_x[i*6 +: 6] = 6'(x);
        req_y[i*6 +: 6] = 6'(y);
    endtask

    function automatic int rnd_coord();
        if ($urandom_range(0, 9) == 0) return int'($urandom_range(60, 63));
        return int'($urandom_range(0, 59));
    endfunction

    initial begin
        n_vec      = 0;
        n_err      = 0;
        cyc        = 0;
        m_rr       = 0;
        exp_addr   = 0;
        addr_known = 1'b0;
        last_gnt   = 3'b000;
        for (int a = 0; a < 3600; a++) mem[a] = 3'($urandom);
        mem[3*60 + 5] = 3'd4;
        mem[3599]     = 3'd6;
        mem[10*60 + 60 - 60] = 3'd7;
        resetn = 1'b0;
        req    = 3'b000;
        req_x  = '0;
        req_y  = '0;
        #1;
        cycle();
        cycle();
        resetn = 1'b1;

        // Single read from requester 1 at (5,3).
        set_req(1, 1'b1, 5, 3);
        cycle();
        req = 3'b000;
        repeat (3) cycle();

        // Full contention.
        set_req(0, 1'b1, 1, 2);
        set_req(1, 1'b1, 59, 0);
        set_req(2, 1'b1, 0, 59);
        repeat (4) cycle();
        req = 3'b000;
        repeat (3) cycle();

        // Fairness: requester 0 always asking, requester 2 joins later.
        set_req(0, 1'b1, 7, 7);
        repeat (5) cycle();
        set_req(2, 1'b1, 8, 9);
        repeat (6) cycle();
        req = 3'b000;
        repeat (3) cycle();

        // Boundary coordinates.
        set_req(0, 1'b1, 59, 59);
        cycle();
        set_req(0, 1'b1, 60, 10);
        cycle();
        set_req(0, 1'b1, 10, 63);
        cycle();
        req = 3'b000;
        repeat (3) cycle();

        // Reset while reads are in flight.
        set_req(0, 1'b1, 3, 3);
        set_req(1, 1'b1, 4, 4);
        set_req(2, 1'b1, 5, 5);
        repeat (2) cycle();
        req    = 3'b000;
        resetn = 1'b0;
        cycle();
        resetn = 1'b1;
        cycle();
        set_req(1, 1'b1, 20, 30);
        set_req(2, 1'b1, 40, 50);
        repeat (2) cycle();
        req = 3'b000;

        // Idle.
        repeat (10) cycle();

        // Random traffic honouring the hold-until-granted handshake.
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] || last_gnt[i]) begin
                    set_req(i, $urandom_range(0, 3) != 0, rnd_coord(), rnd_coord());
                end
            end
            resetn = ($urandom_range(0, 199) != 0);
            cycle();
        end
        resetn = 1'b1;
        req    = 3'b000;
        repeat (4) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
